// File: rtl/grav_accel_engine.sv
// grav_accel_engine
//   Computes softened gravitational acceleration for every body of the shared datafile:
//   a_i = sum_{j!=i} G*m_j*d_ij*(|d_ij|^2+EPS)^-1.5, IEEE-754 single precision.
//   Writes ACC_X/Y/Z[i] through the 3-port write interface, one strobe per body.
//   The reciprocal square root comes from a shared external unit (req/ack handshake).
// Ports
//   CLK, RESET                  clock, synchronous active-high reset
//   ACC_START / ACC_DONE        level request / high while in DONE
//   ACC_ERR                     sticky rsqrt-timeout flag
//   datafile[0:112]             shared data words (count@1, MASS@3, POS@23/33/43)
//   ACC_we, ADDR1..3, data1..3  acceleration write port (ACC@83/93/103 + i)
//   rsq_req/rsq_in/rsq_ack/rsq_out  reciprocal-sqrt unit handshake
// Configuration
//   GRAV_RSQ_TIMEOUT_EN: watchdog on the rsqrt wait; a stalled pair contributes +0.0
//   and ACC_ERR is set. Without it the wait is unbounded and ACC_ERR stays 0.
module grav_accel_engine #(
    parameter int          MAX_BODIES  = 10,
    parameter logic [31:0] G_CONST     = 32'h3F800000,
    parameter logic [31:0] EPS         = 32'h3C23D70A,
    parameter int          RSQ_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ACC_START,
    output logic        ACC_DONE,
    output logic        ACC_ERR,
    input  logic [31:0] datafile [0:112],
    output logic        ACC_we,
    output logic [31:0] ADDR1,
    output logic [31:0] ADDR2,
    output logic [31:0] ADDR3,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [31:0] data3,
    output logic        rsq_req,
    output logic [31:0] rsq_in,
    input  logic        rsq_ack,
    input  logic [31:0] rsq_out
);

    typedef enum logic [4:0] {
        S_IDLE, S_LOAD_I, S_PAIR_CHK, S_DIFF, S_DIFF_W, S_SQ, S_SQ_W, S_R2_A, S_R2_W,
        S_R2_B, S_R2_BW, S_RSQ, S_SCALE_1, S_SCALE_2, S_SCALE_3, S_ACCUM, S_ACCUM_W,
        S_WRITE, S_DONE
    } state_t;

    localparam logic [3:0] LP_MAXN = 4'(MAX_BODIES);

    // Round-to-nearest-even and pack; m has its leading one at bit 47. Denormals flush to zero.
    function automatic logic [31:0] fp_pack(input logic sgn, input logic signed [9:0] e_in,
                                            input logic [47:0] m);
        logic [24:0]       r;
        logic signed [9:0] e;
        logic              rnd;
        e   = e_in;
        rnd = m[23] & ((|m[22:0]) | m[24]);
        r   = {1'b0, m[47:24]} + {24'd0, rnd};
        if (r[24]) begin
            e = e + 10'sd1;
            r = r >> 1;
        end
        if (e <= 10'sd0)        return {sgn, 31'd0};
        else if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
        else                    return {sgn, e[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       p;
        logic signed [9:0] e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) e = e + 10'sd1;
        else       p = p << 1;
        return fp_pack(a[31] ^ b[31], e, p);
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y;
        logic [7:0]        d;
        logic [48:0]       mx, my0, my, s;
        logic [47:0]       mn;
        logic signed [9:0] e;
        int                k;
        if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? 32'd0 : b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        d   = x[30:23] - y[30:23];
        mx  = {2'b01, x[22:0], 24'd0};
        my0 = {2'b01, y[22:0], 24'd0};
        // Bits shifted out of the smaller operand collapse into a sticky LSB.
        if (d > 8'd48) begin
            my = 49'd1;
        end else begin
            my    = my0 >> d;
            my[0] = my[0] | ((my << d) != my0);
        end
        s = (x[31] == y[31]) ? (mx + my) : (mx - my);
        if (s == 49'd0) return 32'd0;
        k = 0;
        for (int i = 0; i < 49; i++) if (s[i]) k = i;
        e = $signed({2'b00, x[30:23]}) + 10'(k - 47);
        if (k == 48) mn = s[48:1] | {47'd0, s[0]};
        else         mn = 48'(s << (47 - k));
        return fp_pack(x[31], e, mn);
    endfunction

    state_t      r_state;
    logic [3:0]  r_i, r_j;
    logic [31:0] r_acc [3];
    logic [31:0] r_d   [3];
    logic [31:0] r_sum [3];
    logic [31:0] r_tmp, r_s, r_t1, r_t2, r_t3, r_k;
    logic        r_done, r_err, r_we, r_rsq_req;
    logic [31:0] r_rsq_in, r_addr1, r_addr2, r_addr3, r_data1, r_data2, r_data3;
`ifdef GRAV_RSQ_TIMEOUT_EN
    logic [7:0]  r_rsq_cnt;
    localparam logic [7:0] LP_TMO_LAST = 8'(RSQ_TIMEOUT - 1);
`else
    logic [7:0]  w_unused_tmo;
    assign w_unused_tmo = 8'(RSQ_TIMEOUT);
`endif

    logic [3:0]  w_cnt, w_n;
    logic [31:0] w_mj;
    logic [31:0] w_pi [3];
    logic [31:0] w_pj [3];
    logic [31:0] w_ma [3];
    logic [31:0] w_mb [3];
    logic [31:0] w_mp [3];
    logic [31:0] w_aa [3];
    logic [31:0] w_ab [3];
    logic        w_unused_df;

    assign w_cnt = datafile[1][3:0];
    assign w_n   = (w_cnt > LP_MAXN) ? LP_MAXN : w_cnt;
    assign w_mj  = datafile[7'd3 + {3'd0, r_j}];

    // Operands of body i and body j, read live from the datafile.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_pi[k] = datafile[7'd23 + 7'(10 * k) + {3'd0, r_i}];
            w_pj[k] = datafile[7'd23 + 7'(10 * k) + {3'd0, r_j}];
        end
    end

    // Fold the words this stage never consumes into a dangling net.
    always_comb begin
        w_unused_df = 1'b0;
        for (int k = 0; k < 113; k++) w_unused_df = w_unused_df ^ (^datafile[k]);
    end

    // Multiplier lane operand select and the three combinational products.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_ma[k] = 32'd0;
            w_mb[k] = 32'd0;
        end
        case (r_state)
            S_SQ, S_R2_A: for (int k = 0; k < 3; k++) begin w_ma[k] = r_d[k]; w_mb[k] = r_d[k]; end
            S_SCALE_1:    begin w_ma[0] = r_s; w_mb[0] = r_s; w_ma[1] = G_CONST; w_mb[1] = w_mj; end
            S_SCALE_2:    begin w_ma[0] = r_t1; w_mb[0] = r_s; end
            S_SCALE_3:    begin w_ma[0] = r_t3; w_mb[0] = r_t2; end
            S_ACCUM:      for (int k = 0; k < 3; k++) begin w_ma[k] = r_k; w_mb[k] = r_d[k]; end
            default:      ;
        endcase
        for (int k = 0; k < 3; k++) w_mp[k] = fp_mul(w_ma[k], w_mb[k]);
    end

    // Adder lane operand select; subtraction flips the sign of operand B.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_aa[k] = 32'd0;
            w_ab[k] = 32'd0;
        end
        case (r_state)
            S_DIFF:  for (int k = 0; k < 3; k++) begin
                         w_aa[k] = w_pj[k];
                         w_ab[k] = {~w_pi[k][31], w_pi[k][30:0]};
                     end
            S_SQ:    begin w_aa[0] = w_mp[0]; w_ab[0] = w_mp[1]; end
            S_R2_A:  begin w_aa[0] = r_tmp;   w_ab[0] = w_mp[2]; end
            S_R2_B:  begin w_aa[0] = r_tmp;   w_ab[0] = EPS; end
            S_ACCUM: for (int k = 0; k < 3; k++) begin w_aa[k] = r_acc[k]; w_ab[k] = w_mp[k]; end
            default: ;
        endcase
    end

    // Registered adder lanes: result available the cycle after operands are applied.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (RESET) r_sum[k] <= 32'd0;
            else       r_sum[k] <= fp_add(w_aa[k], w_ab[k]);
        end
    end

    // Sequencer: pair loop over (i, j), rsqrt handshake, and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_i <= 4'd0;  r_j <= 4'd0;
            for (int k = 0; k < 3; k++) begin r_acc[k] <= 32'd0; r_d[k] <= 32'd0; end
            r_tmp <= 32'd0; r_s <= 32'd0; r_t1 <= 32'd0; r_t2 <= 32'd0; r_t3 <= 32'd0; r_k <= 32'd0;
            r_done <= 1'b0; r_err <= 1'b0; r_we <= 1'b0; r_rsq_req <= 1'b0; r_rsq_in <= 32'd0;
            r_addr1 <= 32'd0; r_addr2 <= 32'd0; r_addr3 <= 32'd0;
            r_data1 <= 32'd0; r_data2 <= 32'd0; r_data3 <= 32'd0;
`ifdef GRAV_RSQ_TIMEOUT_EN
            r_rsq_cnt <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (ACC_START) begin
                    r_i   <= 4'd0;
                    r_err <= 1'b0;
                    if (w_n == 4'd0) begin r_state <= S_DONE; r_done <= 1'b1; end
                    else             r_state <= S_LOAD_I;
                end
                S_LOAD_I: begin
                    for (int k = 0; k < 3; k++) r_acc[k] <= 32'd0;
                    r_j     <= 4'd0;
                    r_state <= S_PAIR_CHK;
                end
                S_PAIR_CHK: begin
                    if (r_j == w_n) begin
                        r_we    <= 1'b1;
                        r_addr1 <= 32'd83  + {28'd0, r_i};
                        r_addr2 <= 32'd93  + {28'd0, r_i};
                        r_addr3 <= 32'd103 + {28'd0, r_i};
                        r_data1 <= r_acc[0]; r_data2 <= r_acc[1]; r_data3 <= r_acc[2];
                        r_state <= S_WRITE;
                    end else if (r_j == r_i) begin
                        r_j <= r_j + 4'd1;
                    end else begin
                        r_state <= S_DIFF;
                    end
                end
                S_DIFF:   r_state <= S_DIFF_W;
                S_DIFF_W: begin
                    for (int k = 0; k < 3; k++) r_d[k] <= r_sum[k];
                    r_state <= S_SQ;
                end
                S_SQ:     r_state <= S_SQ_W;
                S_SQ_W:   begin r_tmp <= r_sum[0]; r_state <= S_R2_A; end
                S_R2_A:   r_state <= S_R2_W;
                S_R2_W:   begin r_tmp <= r_sum[0]; r_state <= S_R2_B; end
                S_R2_B:   r_state <= S_R2_BW;
                S_R2_BW:  begin
                    r_rsq_in  <= r_sum[0];
                    r_rsq_req <= 1'b1;
`ifdef GRAV_RSQ_TIMEOUT_EN
                    r_rsq_cnt <= 8'd0;
`endif
                    r_state   <= S_RSQ;
                end
                S_RSQ: begin
                    if (rsq_ack) begin
                        r_s       <= rsq_out;
                        r_rsq_req <= 1'b0;
                        r_state   <= S_SCALE_1;
`ifdef GRAV_RSQ_TIMEOUT_EN
                    end else if (r_rsq_cnt == LP_TMO_LAST) begin
                        // Give up on this pair: s=0 makes k=0, so it adds +0.0.
                        r_s       <= 32'd0;
                        r_rsq_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_SCALE_1;
                    end else begin
                        r_rsq_cnt <= r_rsq_cnt + 8'd1;
`endif
                    end
                end
                S_SCALE_1: begin r_t1 <= w_mp[0]; r_t2 <= w_mp[1]; r_state <= S_SCALE_2; end
                S_SCALE_2: begin r_t3 <= w_mp[0]; r_state <= S_SCALE_3; end
                S_SCALE_3: begin r_k  <= w_mp[0]; r_state <= S_ACCUM; end
                S_ACCUM:   r_state <= S_ACCUM_W;
                S_ACCUM_W: begin
                    for (int k = 0; k < 3; k++) r_acc[k] <= r_sum[k];
                    r_j     <= r_j + 4'd1;
                    r_state <= S_PAIR_CHK;
                end
                S_WRITE: begin
                    r_we <= 1'b0;
                    r_i  <= r_i + 4'd1;
                    if ((r_i + 4'd1) == w_n) begin r_state <= S_DONE; r_done <= 1'b1; end
                    else                     r_state <= S_LOAD_I;
                end
                S_DONE: if (!ACC_START) begin r_state <= S_IDLE; r_done <= 1'b0; end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ACC_DONE = r_done;
    assign ACC_ERR  = r_err;
    assign ACC_we   = r_we;
    assign ADDR1 = r_addr1;  assign ADDR2 = r_addr2;  assign ADDR3 = r_addr3;
    assign data1 = r_data1;  assign data2 = r_data2;  assign data3 = r_data3;
    assign rsq_req  = r_rsq_req;
    assign rsq_in   = r_rsq_in;

endmodule

// File: tb/tb_grav_accel_engine.sv
// Directed bench for grav_accel_engine (EPS overridden to 0 so unit cases are exact).
module tb_grav_accel_engine;

    logic        CLK = 1'b0;
    logic        RESET, ACC_START, ACC_DONE, ACC_ERR, ACC_we, rsq_req, rsq_ack;
    logic [31:0] ADDR1, ADDR2, ADDR3, data1, data2, data3, rsq_in, rsq_out;
    logic [31:0] datafile [0:112];

    int n_checks = 0;
    int n_errors = 0;
    bit stub_en  = 1'b1;
    int wr_total = 0;
    logic [31:0] wr_a1 [128];
    logic [31:0] wr_a3 [128];
    logic [31:0] wr_d1 [128];
    logic [31:0] wr_d2 [128];
    logic [31:0] wr_d3 [128];

    always #5 CLK = ~CLK;

    grav_accel_engine #(.EPS(32'h00000000)) u_dut (
        .CLK(CLK), .RESET(RESET), .ACC_START(ACC_START), .ACC_DONE(ACC_DONE), .ACC_ERR(ACC_ERR),
        .datafile(datafile), .ACC_we(ACC_we), .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3),
        .data1(data1), .data2(data2), .data3(data3),
        .rsq_req(rsq_req), .rsq_in(rsq_in), .rsq_ack(rsq_ack), .rsq_out(rsq_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        logic        s;
        int          e, f;
        real         m;
        if (x == 0.0) return 32'd0;
        s = (x < 0.0);
        m = s ? -x : x;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = $rtoi((m - 1.0) * 8388608.0 + 0.5);
        if (f == 8388608) begin f = 0; e++; end
        return {s, 8'(e), 23'(f)};
    endfunction

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    // rsqrt stub: exact result, random 0..5 cycle ack delay.
    initial begin
        int dly;
        rsq_ack = 1'b0;
        rsq_out = 32'd0;
        dly = $urandom_range(0, 5);
        forever begin
            @(negedge CLK);
            rsq_ack = 1'b0;
            if (rsq_req === 1'b1 && stub_en) begin
                if (dly == 0) begin
                    rsq_out = r2f(1.0 / $sqrt(f2r(rsq_in)));
                    rsq_ack = 1'b1;
                    dly = $urandom_range(0, 5);
                end else begin
                    dly--;
                end
            end
        end
    end

    // Write-port monitor.
    initial begin
        forever begin
            @(negedge CLK);
            if (ACC_we === 1'b1) begin
                wr_a1[wr_total % 128] = ADDR1;
                wr_a3[wr_total % 128] = ADDR3;
                wr_d1[wr_total % 128] = data1;
                wr_d2[wr_total % 128] = data2;
                wr_d3[wr_total % 128] = data3;
                wr_total++;
            end
        end
    end

    task automatic clear_df();
        for (int k = 0; k < 113; k++) datafile[k] = 32'd0;
    endtask

    task automatic set_body(input int k, input logic [31:0] m, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] z);
        datafile[3 + k]  = m;
        datafile[23 + k] = x;
        datafile[33 + k] = y;
        datafile[43 + k] = z;
    endtask

    // Raise ACC_START and wait (bounded) for ACC_DONE; START stays high on return.
    task automatic run_pass(input string tag, input int max_cyc);
        int cyc;
        ACC_START = 1'b1;
        cyc = 0;
        while (ACC_DONE !== 1'b1 && cyc < max_cyc) begin
            @(negedge CLK);
            cyc++;
        end
        check_val({tag, "_done"}, {31'd0, ACC_DONE}, 32'd1);
    endtask

    task automatic end_pass();
        ACC_START = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int  base, cyc;
        real px [3], py [3];
        real ax [3], ay [3];
        real gx, gy, dx, dy, r2, f, mag [3];
        RESET = 1'b1;
        ACC_START = 1'b0;
        clear_df();
        repeat (3) @(negedge CLK);
        check_val("rst_done", {31'd0, ACC_DONE}, 32'd0);
        check_val("rst_we",   {31'd0, ACC_we},   32'd0);
        check_val("rst_req",  {31'd0, rsq_req},  32'd0);
        check_val("rst_err",  {31'd0, ACC_ERR},  32'd0);
        check_val("rst_addr", ADDR1, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // 1: two unit bodies one unit apart on x.
        datafile[1] = 32'd2;
        set_body(0, 32'h3F800000, 32'h00000000, 32'd0, 32'd0);
        set_body(1, 32'h3F800000, 32'h3F800000, 32'd0, 32'd0);
        base = wr_total;
        run_pass("t1", 500);
        check_val("t1_nwr",  32'(wr_total - base), 32'd2);
        check_val("t1_a0",   wr_a1[base % 128],       32'd83);
        check_val("t1_a0z",  wr_a3[base % 128],       32'd103);
        check_val("t1_x0",   wr_d1[base % 128],       32'h3F800000);
        check_val("t1_y0",   wr_d2[base % 128],       32'h00000000);
        check_val("t1_z0",   wr_d3[base % 128],       32'h00000000);
        check_val("t1_a1",   wr_a1[(base + 1) % 128], 32'd84);
        check_val("t1_x1",   wr_d1[(base + 1) % 128], 32'hBF800000);
        check_val("t1_y1",   wr_d2[(base + 1) % 128], 32'h00000000);
        check_val("t1_z1",   wr_d3[(base + 1) % 128], 32'h00000000);
        check_val("t1_err",  {31'd0, ACC_ERR}, 32'd0);
        end_pass();

        // 2: equilateral triangle, compared with a double-precision model.
        clear_df();
        datafile[1] = 32'd3;
        set_body(0, 32'h3F800000, 32'h00000000, 32'h00000000, 32'd0);
        set_body(1, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'd0);
        set_body(2, 32'h3F800000, 32'h3F000000, 32'h3F5DB3D7, 32'd0);
        for (int i = 0; i < 3; i++) begin
            px[i] = f2r(datafile[23 + i]);
            py[i] = f2r(datafile[33 + i]);
        end
        base = wr_total;
        run_pass("t2", 2000);
        check_val("t2_nwr", 32'(wr_total - base), 32'd3);
        gx = 0.0;
        gy = 0.0;
        for (int i = 0; i < 3; i++) begin
            ax[i] = 0.0;
            ay[i] = 0.0;
            for (int j = 0; j < 3; j++) begin
                if (j != i) begin
                    dx = px[j] - px[i];
                    dy = py[j] - py[i];
                    r2 = dx * dx + dy * dy;
                    f  = 1.0 / (r2 * $sqrt(r2));
                    ax[i] = ax[i] + f * dx;
                    ay[i] = ay[i] + f * dy;
                end
            end
            check_val($sformatf("t2_addr%0d", i), wr_a1[(base + i) % 128], 32'(83 + i));
            check_val($sformatf("t2_ax%0d", i),
                      {31'd0, rabs(f2r(wr_d1[(base + i) % 128]) - ax[i]) < 1.0e-5}, 32'd1);
            check_val($sformatf("t2_ay%0d", i),
                      {31'd0, rabs(f2r(wr_d2[(base + i) % 128]) - ay[i]) < 1.0e-5}, 32'd1);
            check_val($sformatf("t2_az%0d", i), wr_d3[(base + i) % 128], 32'd0);
            gx = gx + f2r(wr_d1[(base + i) % 128]);
            gy = gy + f2r(wr_d2[(base + i) % 128]);
            mag[i] = $sqrt(f2r(wr_d1[(base + i) % 128]) ** 2 + f2r(wr_d2[(base + i) % 128]) ** 2);
        end
        check_val("t2_sumx", {31'd0, rabs(gx) < 1.0e-6}, 32'd1);
        check_val("t2_sumy", {31'd0, rabs(gy) < 1.0e-6}, 32'd1);
        check_val("t2_mag01", {31'd0, rabs(mag[0] - mag[1]) < 1.0e-6 * mag[0]}, 32'd1);
        check_val("t2_mag02", {31'd0, rabs(mag[0] - mag[2]) < 1.0e-6 * mag[0]}, 32'd1);
        end_pass();

        // 3a: zero bodies -> DONE quickly, no writes.
        clear_df();
        base = wr_total;
        ACC_START = 1'b1;
        cyc = 0;
        while (ACC_DONE !== 1'b1 && cyc < 3) begin
            @(negedge CLK);
            cyc++;
        end
        check_val("t3_n0_done", {31'd0, ACC_DONE}, 32'd1);
        check_val("t3_n0_nwr", 32'(wr_total - base), 32'd0);
        end_pass();

        // 3b: count 15 clamps to 10 bodies.
        datafile[1] = 32'd15;
        for (int k = 0; k < 10; k++) set_body(k, 32'h3F800000, r2f(real'(k)), 32'd0, 32'd0);
        base = wr_total;
        run_pass("t3_n15", 20000);
        check_val("t3_n15_nwr", 32'(wr_total - base), 32'd10);
        for (int k = 0; k < 10; k++)
            check_val($sformatf("t3_addr%0d", k), wr_a1[(base + k) % 128], 32'(83 + k));
        check_val("t3_last_z", wr_a3[(base + 9) % 128], 32'd112);
        end_pass();

        // 4: START held in DONE, drop, re-raise.
        clear_df();
        datafile[1] = 32'd2;
        set_body(0, 32'h3F800000, 32'h00000000, 32'd0, 32'd0);
        set_body(1, 32'h3F800000, 32'h3F800000, 32'd0, 32'd0);
        run_pass("t4a", 500);
        repeat (5) @(negedge CLK);
        check_val("t4_hold", {31'd0, ACC_DONE}, 32'd1);
        ACC_START = 1'b0;
        @(negedge CLK);
        check_val("t4_drop", {31'd0, ACC_DONE}, 32'd0);
        base = wr_total;
        run_pass("t4b", 500);
        check_val("t4_rerun_nwr", 32'(wr_total - base), 32'd2);
        end_pass();

        // 5: reset while waiting on rsqrt.
        ACC_START = 1'b1;
        cyc = 0;
        while (rsq_req !== 1'b1 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        check_val("t5_req_seen", {31'd0, rsq_req}, 32'd1);
        RESET = 1'b1;
        ACC_START = 1'b0;
        @(negedge CLK);
        check_val("t5_req", {31'd0, rsq_req}, 32'd0);
        check_val("t5_rin", rsq_in, 32'd0);
        check_val("t5_we",  {31'd0, ACC_we}, 32'd0);
        check_val("t5_done", {31'd0, ACC_DONE}, 32'd0);
        RESET = 1'b0;
        base = wr_total;
        repeat (30) @(negedge CLK);
        check_val("t5_nwr", 32'(wr_total - base), 32'd0);

`ifdef GRAV_RSQ_TIMEOUT_EN
        // 6: rsqrt never acks -> both pairs time out, zero accelerations, sticky error.
        stub_en = 1'b0;
        base = wr_total;
        run_pass("t6", 1000);
        check_val("t6_err", {31'd0, ACC_ERR}, 32'd1);
        check_val("t6_nwr", 32'(wr_total - base), 32'd2);
        check_val("t6_x0", wr_d1[base % 128], 32'd0);
        check_val("t6_x1", wr_d1[(base + 1) % 128], 32'd0);
        end_pass();
        stub_en = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
